sample_rr_arb: RTL and testbench

//  Round-robin arbiter sitting directly upstream of the binary-to-one-hot decoder
//  (IN = IDX). Picks one of REQ requesters and holds a registered binary grant

---
 rtl/sample_rr_arb.sv | 70 +++++++
 tb/tb_sample_rr_arb.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sample_rr_arb.sv
// sample_rr_arb: round-robin arbiter holding a registered binary grant index until release or hold timeout
module sample_rr_arb #(
  parameter  int IDX      = 4,
  parameter  int MAX_HOLD = 64,
  localparam int REQ      = 1 << IDX,
  localparam int HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           reset_,
  input  logic [REQ-1:0] req,
  input  logic           release_,
  output logic           grant_valid,
  output logic [IDX-1:0] grant_idx,
  output logic           timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t         state, state_nx;
  logic [IDX-1:0] ptr, ptr_nx, idx_nx, win, cand;
  logic [HW-1:0]  hold_cnt, hold_nx;
  logic           timeout_nx;
  // grant is live exactly while in GRANT, so it comes straight off the state flop
  assign grant_valid = (state == GRANT);
  // rotating priority scan: walk offsets high to low so the closest set bit at/after ptr wins
  always_comb begin
    win  = ptr;
    cand = ptr;
    for (int i = REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX'(i);
      if (req[cand]) win = cand;
    end
  end
  // next-state: grab a winner from IDLE, end the grant on release or when the hold budget is spent
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    idx_nx     = grant_idx;
    hold_nx    = hold_cnt;
    timeout_nx = 1'b0;
    if (state == IDLE) begin
      if (|req) begin
        state_nx = GRANT;
        idx_nx   = win;
        hold_nx  = HW'(1);
      end
    end else if (release_ || hold_cnt == HW'(MAX_HOLD)) begin
      state_nx   = IDLE;
      ptr_nx     = grant_idx + 1'b1;
      hold_nx    = '0;
      timeout_nx = !release_;
    end else begin
      hold_nx = hold_cnt + 1'b1;
    end
  end
  // all state and outputs registered; async reset clears everything including a pending timeout
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      grant_idx <= idx_nx;
      hold_cnt  <= hold_nx;
      timeout   <= timeout_nx;
    end
  end
endmodule

// File: tb/tb_sample_rr_arb.sv
// tb_sample_rr_arb: directed scoreboard bench for the round-robin arbiter
module tb_sample_rr_arb;
  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic [15:0] req = 16'hFFFF;
  logic        release_ = 1'b0;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic        timeout;
  int          checks = 0;
  int          failures = 0;
  logic [3:0]  exp_q[$];

  sample_rr_arb #(.IDX(4), .MAX_HOLD(4)) dut (
    .clk(clk), .reset_(reset_), .req(req), .release_(release_),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic grant(input logic [15:0] r, input logic [3:0] e);
    req = r;
    exp_q.push_back(e);
    tick();
    chk("grant_valid_up", grant_valid, 1);
    chk("timeout_on_grant", timeout, 0);
    if (exp_q.size() > 0) chk("grant_idx", grant_idx, exp_q.pop_front());
  endtask

  task automatic rel();
    release_ = 1'b1;
    tick();
    release_ = 1'b0;
    chk("grant_valid_down", grant_valid, 0);
    chk("timeout_on_release", timeout, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", grant_valid, 0);
      chk("rst_idx", grant_idx, 0);
      chk("rst_timeout", timeout, 0);
    end
    reset_ = 1'b1;
    req = 16'h0000;
    tick();
    chk("idle_no_req", grant_valid, 0);
    grant(16'h0020, 4'd5);
    req = 16'h0000;
    rel();
    release_ = 1'b1;
    tick();
    release_ = 1'b0;
    chk("release_in_idle", grant_valid, 0);
    reset_ = 1'b0;
    #1;
    reset_ = 1'b1;
    for (int i = 0; i < 17; i++) begin
      grant(16'hFFFF, 4'(i));
      tick();
      chk("fair_hold", grant_valid, 1);
      rel();
    end
    grant(16'h2000, 4'd13);
    rel();
    grant(16'h0009, 4'd0);
    rel();
    grant(16'h0009, 4'd3);
    rel();
    grant(16'h0100, 4'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_hold", grant_valid, 1);
      chk("to_hold_pulse", timeout, 0);
    end
    req = 16'h0000;
    tick();
    chk("to_drop_valid", grant_valid, 0);
    chk("to_pulse", timeout, 1);
    tick();
    chk("to_pulse_end", timeout, 0);
    chk("to_idle", grant_valid, 0);
    grant(16'h0100, 4'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rel_max_hold", grant_valid, 1);
    end
    req = 16'h0000;
    rel();
    grant(16'h0080, 4'd7);
    #2;
    reset_ = 1'b0;
    #1;
    chk("async_rst_valid", grant_valid, 0);
    chk("async_rst_idx", grant_idx, 0);
    chk("async_rst_timeout", timeout, 0);
    tick();
    chk("rst_hold_valid", grant_valid, 0);
    chk("rst_hold_timeout", timeout, 0);
    reset_ = 1'b1;
    grant(16'h0080, 4'd7);
    rel();
    grant(16'hFFFF, 4'd8);
    rel();
    req = 16'h0000;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
